// File: rtl/volume_level_ctrl_pkg.sv
// Shared constants, state codes and the mic-to-level quantizer
// for the OLED volume bar controller.
package volume_level_ctrl_pkg;

  localparam logic [6:0] X_HOME  = 7'd43;
  localparam logic [6:0] X_STEP  = 7'd5;
  localparam logic [6:0] BAR_LEN = 7'd10;
  localparam logic [6:0] X_MAX   = 7'd95;

  localparam logic [11:0] MIC_MID = 12'd2048;

  localparam logic [3:0] ST_RESET = 4'b0000;
  localparam logic [3:0] ST_MOVE  = 4'b0001;

  localparam logic [1:0] PK_TRACK = 2'd0;
  localparam logic [1:0] PK_HOLD  = 2'd1;
  localparam logic [1:0] PK_DECAY = 2'd2;

  // Codes at or below mid are silence; above it, 128 codes per level.
  function automatic logic [3:0] quantize(
    input logic [11:0] m,
    input logic [11:0] mid
  );
    logic [11:0] d;
    d = m - mid;
    if (m <= mid) return 4'd0;
    return 4'(d >> 7);
  endfunction

endpackage

// File: rtl/volume_peak_hold.sv
// Peak-hold marker: follows rising levels, holds for a number
// of windows, then decays one step per window.
module volume_peak_hold
  import volume_level_ctrl_pkg::*;
#(
  parameter int HOLD_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win_end,
  input  logic [3:0] level_in,
  output logic [3:0] peak_level
);

  localparam int HCW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [HCW-1:0] HOLD_R = HCW'(HOLD_WINDOWS);

  logic [1:0]     st_q, st_d;
  logic [3:0]     peak_q, peak_d;
  logic [HCW-1:0] hold_q, hold_d;

  // level >= peak-1 written as level+1 >= peak to avoid underflow
  logic near_peak;
  assign near_peak = ({1'b0, level_in} + 5'd1) >= {1'b0, peak_q};

  always_comb begin
    st_d   = st_q;
    peak_d = peak_q;
    hold_d = hold_q;
    if (win_end) begin
      unique case (st_q)
        PK_TRACK: begin
          peak_d = level_in;
          if (level_in != 4'd0) begin
            st_d   = PK_HOLD;
            hold_d = HOLD_R;
          end
        end
        PK_HOLD: begin
          if (level_in >= peak_q) begin
            peak_d = level_in;
            hold_d = HOLD_R;
          end else begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HCW'(1)) st_d = PK_DECAY;
          end
        end
        PK_DECAY: begin
          if (near_peak) begin
            peak_d = level_in;
            if (level_in != 4'd0) begin
              st_d   = PK_HOLD;
              hold_d = HOLD_R;
            end else begin
              st_d = PK_TRACK;
            end
          end else begin
            peak_d = peak_q - 4'd1;
          end
        end
        default: st_d = PK_TRACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= PK_TRACK;
      peak_q <= 4'd0;
      hold_q <= '0;
    end else begin
      st_q   <= st_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign peak_level = peak_q;

endmodule

// File: rtl/volume_level_ctrl.sv
// Mic window level meter with peak hold, plus button-driven
// horizontal position of the volume bar.
module volume_level_ctrl
  import volume_level_ctrl_pkg::*;
#(
  parameter int          WINDOW       = 4000,
  parameter int          HOLD_WINDOWS = 3,
  parameter logic [11:0] MIC_MID_P    = MIC_MID,
  parameter logic [6:0]  X_HOME_P     = X_HOME,
  parameter logic [6:0]  X_STEP_P     = X_STEP,
  parameter logic [6:0]  BAR_LEN_P    = BAR_LEN,
  parameter logic [6:0]  X_MAX_P      = X_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [11:0] mic_in,
  input  logic        btnL_pulse,
  input  logic        btnR_pulse,
  input  logic [3:0]  state,
  input  logic [1:0]  border_width,
  output logic [3:0]  level,
  output logic [3:0]  peak_level,
  output logic        level_valid,
  output logic [6:0]  left_x
);

  localparam int CW = $clog2(WINDOW);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   win_max_q, win_max_d;
  logic [3:0]    level_q, level_d;
  logic          valid_q, valid_d;
  logic [6:0]    x_q, x_d;

  logic [11:0] m_cur;
  logic [3:0]  lvl_new;
  logic        win_end;

  assign m_cur   = (mic_in > win_max_q) ? mic_in : win_max_q;
  assign lvl_new = quantize(m_cur, MIC_MID_P);
  assign win_end = sample_en && (cnt_q == CW'(WINDOW - 1));

  always_comb begin
    cnt_d     = cnt_q;
    win_max_d = win_max_q;
    level_d   = level_q;
    valid_d   = 1'b0;
    if (win_end) begin
      cnt_d     = '0;
      win_max_d = '0;
      level_d   = lvl_new;
      valid_d   = 1'b1;
    end else if (sample_en) begin
      cnt_d     = cnt_q + 1'b1;
      win_max_d = m_cur;
    end
  end

  logic       mv_l, mv_r;
  logic [6:0] lim_l, lim_r;

  assign lim_l = {5'd0, border_width} + X_STEP_P;
  assign lim_r = X_MAX_P - {5'd0, border_width} - BAR_LEN_P - X_STEP_P;
  assign mv_l  = (state == ST_MOVE) && btnL_pulse && !btnR_pulse
                 && (x_q > lim_l);
  assign mv_r  = (state == ST_MOVE) && btnR_pulse && !btnL_pulse
                 && (x_q <= lim_r);

  always_comb begin
    x_d = x_q;
    unique case (1'b1)
      (state == ST_RESET): x_d = X_HOME_P;
      mv_l:                x_d = x_q - X_STEP_P;
      mv_r:                x_d = x_q + X_STEP_P;
      default:             x_d = x_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      win_max_q <= '0;
      level_q   <= 4'd0;
      valid_q   <= 1'b0;
      x_q       <= X_HOME_P;
    end else begin
      cnt_q     <= cnt_d;
      win_max_q <= win_max_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
    end
  end

  volume_peak_hold #(
    .HOLD_WINDOWS(HOLD_WINDOWS)
  ) u_peak (
    .clk       (clk),
    .rst_n     (rst_n),
    .win_end   (win_end),
    .level_in  (lvl_new),
    .peak_level(peak_level)
  );

  assign level       = level_q;
  assign level_valid = valid_q;
  assign left_x      = x_q;

endmodule

// File: tb/tb_volume_level_ctrl.sv
// Randomized bench for volume_level_ctrl with a reference model
// built on sample queues and plain arithmetic.
module tb_volume_level_ctrl;

  localparam int W = 500;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [11:0] mic_in;
  logic        btnL_pulse;
  logic        btnR_pulse;
  logic [3:0]  state;
  logic [1:0]  border_width;
  logic [3:0]  level;
  logic [3:0]  peak_level;
  logic        level_valid;
  logic [6:0]  left_x;

  volume_level_ctrl #(.WINDOW(W), .HOLD_WINDOWS(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .mic_in      (mic_in),
    .btnL_pulse  (btnL_pulse),
    .btnR_pulse  (btnR_pulse),
    .state       (state),
    .border_width(border_width),
    .level       (level),
    .peak_level  (peak_level),
    .level_valid (level_valid),
    .left_x      (left_x)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int q_samp[$];
  int m_level, m_peak, m_st, m_hold, m_x;
  bit m_valid;

  task automatic model_reset();
    q_samp.delete();
    m_level = 0; m_peak = 0; m_st = 0; m_hold = 0;
    m_x = 43; m_valid = 0;
  endtask

  function automatic int quant(int m);
    return (m <= 2048) ? 0 : (m - 2048) / 128;
  endfunction

  task automatic model_peak(int l);
    case (m_st)
      0: begin
        m_peak = l;
        if (l > 0) begin m_st = 1; m_hold = H; end
      end
      1: begin
        if (l >= m_peak) begin
          m_peak = l; m_hold = H;
        end else begin
          m_hold--;
          if (m_hold == 0) m_st = 2;
        end
      end
      default: begin
        if (l >= m_peak - 1) begin
          m_peak = l;
          if (l > 0) begin m_st = 1; m_hold = H; end
          else m_st = 0;
        end else begin
          m_peak--;
        end
      end
    endcase
  endtask

  task automatic cycle(bit se, int m, bit bl, bit br);
    int mx;
    @(negedge clk);
    sample_en = se; mic_in = 12'(m);
    btnL_pulse = bl; btnR_pulse = br;
    @(posedge clk); #1;
    m_valid = 0;
    if (se) begin
      q_samp.push_back(m);
      if (q_samp.size() == W) begin
        mx = 0;
        foreach (q_samp[i]) if (q_samp[i] > mx) mx = q_samp[i];
        m_level = quant(mx);
        model_peak(m_level);
        m_valid = 1;
        q_samp.delete();
      end
    end
    if (state == 4'd0) m_x = 43;
    else if (state == 4'd1) begin
      if (bl && !br && m_x > int'(border_width) + 5) m_x -= 5;
      else if (br && !bl && m_x <= 95 - int'(border_width) - 10 - 5)
        m_x += 5;
    end
  endtask

  task automatic feed_window(int sv, int sp, output int nv,
                             output bit lastv);
    nv = 0; lastv = 0;
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, (i == sp) ? sv : 2048, 1'b0, 1'b0);
      if (level_valid === 1'b1) nv++;
      lastv = level_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; sample_en = 0; mic_in = 0;
    btnL_pulse = 0; btnR_pulse = 0; state = 0; border_width = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({level, peak_level, level_valid, left_x} !== {4'd0, 4'd0, 1'b0, 7'd43}) begin
      errors++;
      $display("FAIL reset_vals got l=%0d p=%0d v=%0b x=%0d exp 0 0 0 43",
               level, peak_level, level_valid, left_x);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_silence();
    int nv; bit lv;
    feed_window(2048, 0, nv, lv);
    vectors++;
    if (nv !== 1 || lv !== 1'b1) begin
      errors++;
      $display("FAIL silence_valid got cnt=%0d last=%0b exp 1 1", nv, lv);
    end
    vectors++;
    if (level !== 4'd0 || peak_level !== 4'd0) begin
      errors++;
      $display("FAIL silence_lvl got %0d/%0d exp 0/0", level, peak_level);
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
    vectors++;
    if (level_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width got %0b exp 0", level_valid);
    end
  endtask

  task automatic test_peak_decay();
    int nv; bit lv; int ep;
    for (int k = 0; k < 20; k++) begin
      feed_window((k == 0) ? 4095 : 2048,
                  (k == 0) ? int'($urandom_range(0, W - 1)) : -1, nv, lv);
      ep = (k <= 3) ? 15 : ((15 - (k - 3)) > 0 ? 15 - (k - 3) : 0);
      vectors++;
      if (level !== 4'(m_level) || peak_level !== 4'(m_peak)) begin
        errors++;
        $display("FAIL decay_model w%0d got %0d/%0d exp %0d/%0d",
                 k, level, peak_level, m_level, m_peak);
      end
      vectors++;
      if (peak_level !== 4'(ep) || nv !== 1) begin
        errors++;
        $display("FAIL decay_seq w%0d got p=%0d n=%0d exp p=%0d n=1",
                 k, peak_level, nv, ep);
      end
    end
  endtask

  task automatic test_hold_reload();
    int nv; bit lv;
    int lv_tab[8] = '{8, 10, 0, 0, 0, 0, 0, 0};
    int pk_tab[8] = '{8, 10, 10, 10, 10, 9, 8, 7};
    for (int k = 0; k < 8; k++) begin
      feed_window(2048 + lv_tab[k] * 128 + 5, 7 + k, nv, lv);
      vectors++;
      if (level !== 4'(lv_tab[k]) || peak_level !== 4'(pk_tab[k])) begin
        errors++;
        $display("FAIL hold_reload w%0d got %0d/%0d exp %0d/%0d",
                 k, level, peak_level, lv_tab[k], pk_tab[k]);
      end
      vectors++;
      if (peak_level !== 4'(m_peak)) begin
        errors++;
        $display("FAIL hold_model w%0d got %0d exp %0d",
                 k, peak_level, m_peak);
      end
    end
  endtask

  task automatic test_position();
    state = 0; border_width = 1;
    cycle(1'b0, 0, 1'b0, 1'b0);
    state = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 0, 1'b0, 1'b1);
      vectors++;
      if (left_x !== 7'(m_x)) begin
        errors++;
        $display("FAIL pos_right p%0d got %0d exp %0d", i, left_x, m_x);
      end
      cycle(1'b0, 0, 1'b0, 1'b0);
    end
    vectors++;
    if (left_x !== 7'd83) begin
      errors++;
      $display("FAIL pos_right_lim got %0d exp 83", left_x);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      vectors++;
      if (left_x !== 7'(m_x)) begin
        errors++;
        $display("FAIL pos_left p%0d got %0d exp %0d", i, left_x, m_x);
      end
    end
    vectors++;
    if (left_x !== 7'd3) begin
      errors++;
      $display("FAIL pos_left_lim got %0d exp 3", left_x);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    vectors++;
    if (left_x !== 7'd8) begin
      errors++;
      $display("FAIL pos_both got %0d exp 8", left_x);
    end
    state = 2;
    cycle(1'b0, 0, 1'b0, 1'b1);
    vectors++;
    if (left_x !== 7'd8) begin
      errors++;
      $display("FAIL pos_other_state got %0d exp 8", left_x);
    end
    state = 0;
    cycle(1'b0, 0, 1'b0, 1'b1);
    vectors++;
    if (left_x !== 7'd43) begin
      errors++;
      $display("FAIL pos_home got %0d exp 43", left_x);
    end
  endtask

  task automatic test_random();
    int cap, m, nwin;
    bit se, bl, br;
    nwin = 0;
    cap = $urandom_range(2048, 4095);
    while (nwin < 6) begin
      case ($urandom_range(0, 4))
        0: state = 0;
        1: state = 2;
        default: state = 1;
      endcase
      case ($urandom_range(0, 2))
        0: border_width = 0;
        1: border_width = 1;
        default: border_width = 3;
      endcase
      se = ($urandom_range(0, 1) == 1);
      bl = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 3) == 0);
      m  = $urandom_range(0, cap);
      cycle(se, m, bl, br);
      vectors++;
      if (level_valid !== m_valid || left_x !== 7'(m_x)) begin
        errors++;
        $display("FAIL rand_cycle got v=%0b x=%0d exp v=%0b x=%0d",
                 level_valid, left_x, m_valid, m_x);
      end
      if (m_valid) begin
        nwin++;
        cap = $urandom_range(2048, 4095);
        vectors++;
        if (level !== 4'(m_level) || peak_level !== 4'(m_peak)) begin
          errors++;
          $display("FAIL rand_win w%0d got %0d/%0d exp %0d/%0d",
                   nwin, level, peak_level, m_level, m_peak);
        end
        vectors++;
        if (peak_level < level) begin
          errors++;
          $display("FAIL peak_ge_level got %0d<%0d exp peak>=level",
                   peak_level, level);
        end
      end
    end
    while (q_samp.size() != 0) cycle(1'b1, 2048, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int nv; bit lv;
    state = 0; border_width = 0;
    feed_window(4095, 3, nv, lv);
    state = 1;
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < W / 2; i++)
      cycle(1'b1, (i == 100) ? 4095 : 2048, 1'b0, 1'b0);
    vectors++;
    if (level !== 4'd15 || left_x !== 7'd48) begin
      errors++;
      $display("FAIL pre_reset got l=%0d x=%0d exp 15 48", level, left_x);
    end
    @(negedge clk); #2;
    rst_n = 0; sample_en = 0;
    #1;
    vectors++;
    if ({level, peak_level, level_valid, left_x} !== {4'd0, 4'd0, 1'b0, 7'd43}) begin
      errors++;
      $display("FAIL async_reset got l=%0d p=%0d v=%0b x=%0d exp 0 0 0 43",
               level, peak_level, level_valid, left_x);
    end
    @(negedge clk); rst_n = 1;
    model_reset();
    state = 0;
    feed_window(2048, 0, nv, lv);
    vectors++;
    if (nv !== 1 || lv !== 1'b1 || level !== 4'd0 || peak_level !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_win got n=%0d last=%0b l=%0d p=%0d exp 1 1 0 0",
               nv, lv, level, peak_level);
    end
  endtask

  initial begin
    test_reset();
    test_silence();
    test_peak_decay();
    test_hold_reload();
    test_position();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
